// File: rtl/selfcomp_pkg.sv
// Shared types, default parameters and helpers for the self-composition
// leak monitor.
package selfcomp_pkg;

    // Default sizing of the monitor.
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1024;

    // Transaction tracking states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BOTH  = 2'd1,
        WAIT_OTHER = 2'd2,
        REPORT     = 2'd3
    } state_t;

    // Saturating increment on a value carried in 32 bits. Callers zero-extend
    // their counter into the argument and pass their own all-ones ceiling, so
    // this works for any counter width up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage : selfcomp_pkg

// File: rtl/selfcomp_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Used for the transaction age and for the event counters.
module selfcomp_sat_counter
    import selfcomp_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Ceiling of the counter; it sticks here instead of wrapping.
    localparam logic [31:0] MAX_V = 32'({CNT_W{1'b1}});

    logic [CNT_W-1:0] count_r;

    // Count register: clear first, then saturating increment, else hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= CNT_W'(sat_inc(32'(count_r), MAX_V));
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : selfcomp_sat_counter

// File: rtl/selfcomp_leak_monitor.sv
// Sink for the two SE copies of the self-composition harness. Times each copy
// from the shared input handshake to its result valid, and reports cycle skew
// between the copies (timing leak), result disagreement, timeouts and
// handshake misuse through sticky flags and saturating counters.
module selfcomp_leak_monitor
    import selfcomp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_fire,
    input  logic              validOne,
    input  logic [DATA_W-1:0] resultOne,
    input  logic              validTwo,
    input  logic [DATA_W-1:0] resultTwo,
    input  logic              clear,
    output logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lat_one,
    output logic [CNT_W-1:0]  lat_two,
    output logic [CNT_W-1:0]  skew,
    output logic              leak_detected,
    output logic              mismatch,
    output logic              timeout,
    output logic              protocol_err,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  leak_count
);

    // Latency recorded for a copy that never showed up.
    localparam logic [CNT_W-1:0] LAT_MISSING = {CNT_W{1'b1}};
    localparam logic [31:0]      AGE_MAX     = 32'({CNT_W{1'b1}});
    localparam logic [CNT_W-1:0] TMO_V       = CNT_W'(TIMEOUT);

    // FSM and datapath registers.
    state_t            state_r;
    logic              out_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              got_one_r;
    logic              got_two_r;
    logic [DATA_W-1:0] res_one_r;
    logic [DATA_W-1:0] res_two_r;
    logic [CNT_W-1:0]  lat_one_r;
    logic [CNT_W-1:0]  lat_two_r;
    logic [CNT_W-1:0]  skew_r;

    // Sticky flags.
    logic              leak_r;
    logic              mismatch_r;
    logic              timeout_r;
    logic              proto_r;

    // Next-state / event decode.
    state_t            state_nx_s;
    logic              start_s;
    logic              in_wait_s;
    logic              take_one_s;
    logic              take_two_s;
    logic              got_one_nx_s;
    logic              got_two_nx_s;
    logic              both_s;
    logic              tmo_s;
    logic              to_report_s;
    logic              tmo_hit_s;
    logic [CNT_W-1:0]  age_s;
    logic [CNT_W-1:0]  age_now_s;
    logic [CNT_W-1:0]  fin_one_s;
    logic [CNT_W-1:0]  fin_two_s;
    logic [CNT_W-1:0]  skew_nx_s;
    logic [DATA_W-1:0] res_one_nx_s;
    logic [DATA_W-1:0] res_two_nx_s;
    logic              leak_now_s;
    logic              mismatch_now_s;
    logic              proto_now_s;
    logic [CNT_W-1:0]  txn_count_s;
    logic [CNT_W-1:0]  leak_count_s;

    // Age is cleared when a transaction opens and counts through both wait
    // states. The register lags by one, so the value a copy sees in the
    // first cycle after in_fire is age_now = 1.
    selfcomp_sat_counter #(.CNT_W(CNT_W)) u_age (
        .clock (clock),
        .reset (reset),
        .clear (start_s),
        .inc   (in_wait_s),
        .count (age_s)
    );

    selfcomp_sat_counter #(.CNT_W(CNT_W)) u_txn (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (to_report_s),
        .count (txn_count_s)
    );

    selfcomp_sat_counter #(.CNT_W(CNT_W)) u_leak (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (leak_now_s),
        .count (leak_count_s)
    );

    // Decode consumption, completion, timeout and protocol events.
    always_comb begin
        start_s    = (state_r == IDLE) && in_fire;
        in_wait_s  = (state_r == WAIT_BOTH) || (state_r == WAIT_OTHER);
        age_now_s  = CNT_W'(sat_inc(32'(age_s), AGE_MAX));

        // Only the first valid from each copy is consumed per transaction.
        case (state_r)
            WAIT_BOTH, WAIT_OTHER: begin
                take_one_s = validOne && !got_one_r;
                take_two_s = validTwo && !got_two_r;
            end
            default: begin
                take_one_s = 1'b0;
                take_two_s = 1'b0;
            end
        endcase

        got_one_nx_s = got_one_r || take_one_s;
        got_two_nx_s = got_two_r || take_two_s;
        both_s       = got_one_nx_s && got_two_nx_s;
        tmo_s        = in_wait_s && (age_now_s >= TMO_V);
        to_report_s  = in_wait_s && (both_s || tmo_s);
        tmo_hit_s    = to_report_s && !both_s;

        // Final latencies as they will stand when the transaction closes.
        if (take_one_s) begin
            fin_one_s = age_now_s;
        end else if (got_one_r) begin
            fin_one_s = lat_one_r;
        end else begin
            fin_one_s = LAT_MISSING;
        end
        if (take_two_s) begin
            fin_two_s = age_now_s;
        end else if (got_two_r) begin
            fin_two_s = lat_two_r;
        end else begin
            fin_two_s = LAT_MISSING;
        end

        // Unsigned, larger minus smaller, so no sign handling is needed.
        if (fin_one_s >= fin_two_s) begin
            skew_nx_s = fin_one_s - fin_two_s;
        end else begin
            skew_nx_s = fin_two_s - fin_one_s;
        end

        res_one_nx_s = take_one_s ? resultOne : res_one_r;
        res_two_nx_s = take_two_s ? resultTwo : res_two_r;

        leak_now_s     = to_report_s && ((skew_nx_s != '0) || !both_s);
        mismatch_now_s = to_report_s && both_s && (res_one_nx_s != res_two_nx_s);

        proto_now_s = (in_fire && (state_r != IDLE))
                   || ((validOne || validTwo) && (state_r == IDLE))
                   || ((state_r == WAIT_OTHER)
                       && ((validOne && got_one_r) || (validTwo && got_two_r)));

        case (state_r)
            IDLE: begin
                state_nx_s = in_fire ? WAIT_BOTH : IDLE;
            end
            WAIT_BOTH: begin
                if (to_report_s) begin
                    state_nx_s = REPORT;
                end else if (take_one_s || take_two_s) begin
                    state_nx_s = WAIT_OTHER;
                end else begin
                    state_nx_s = WAIT_BOTH;
                end
            end
            WAIT_OTHER: begin
                state_nx_s = to_report_s ? REPORT : WAIT_OTHER;
            end
            REPORT: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Transaction FSM with its registered outputs and captured copy data.
    // Everything reported with done is written on the edge entering REPORT
    // so it is visible in the same cycle as the pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            out_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            got_one_r   <= 1'b0;
            got_two_r   <= 1'b0;
            res_one_r   <= '0;
            res_two_r   <= '0;
            lat_one_r   <= '0;
            lat_two_r   <= '0;
            skew_r      <= '0;
        end else begin
            state_r     <= state_nx_s;
            out_ready_r <= (state_nx_s == WAIT_BOTH) || (state_nx_s == WAIT_OTHER);
            busy_r      <= (state_nx_s != IDLE);
            done_r      <= to_report_s;

            if (start_s) begin
                got_one_r <= 1'b0;
                got_two_r <= 1'b0;
            end else begin
                got_one_r <= got_one_nx_s;
                got_two_r <= got_two_nx_s;
            end

            if (take_one_s) begin
                res_one_r <= resultOne;
            end
            if (take_two_s) begin
                res_two_r <= resultTwo;
            end

            // Latency latches on arrival; a copy still missing at close
            // records the all-ones marker.
            if (take_one_s) begin
                lat_one_r <= age_now_s;
            end else if (to_report_s && !got_one_nx_s) begin
                lat_one_r <= LAT_MISSING;
            end
            if (take_two_s) begin
                lat_two_r <= age_now_s;
            end else if (to_report_s && !got_two_nx_s) begin
                lat_two_r <= LAT_MISSING;
            end

            if (to_report_s) begin
                skew_r <= skew_nx_s;
            end
        end
    end

    // Sticky flags: clear wins over any event in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leak_r     <= 1'b0;
            mismatch_r <= 1'b0;
            timeout_r  <= 1'b0;
            proto_r    <= 1'b0;
        end else if (clear) begin
            leak_r     <= 1'b0;
            mismatch_r <= 1'b0;
            timeout_r  <= 1'b0;
            proto_r    <= 1'b0;
        end else begin
            leak_r     <= leak_r     || leak_now_s;
            mismatch_r <= mismatch_r || mismatch_now_s;
            timeout_r  <= timeout_r  || tmo_hit_s;
            proto_r    <= proto_r    || proto_now_s;
        end
    end

    assign out_ready     = out_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign lat_one       = lat_one_r;
    assign lat_two       = lat_two_r;
    assign skew          = skew_r;
    assign leak_detected = leak_r;
    assign mismatch      = mismatch_r;
    assign timeout       = timeout_r;
    assign protocol_err  = proto_r;
    assign txn_count     = txn_count_s;
    assign leak_count    = leak_count_s;

endmodule : selfcomp_leak_monitor

// File: doc/selfcomp_leak_monitor.md
Name: selfcomp_leak_monitor

Overview:
Downstream consumer of the two-copy SE self-composition harness. It sinks both SE result streams and times each copy from the shared input handshake to its output valid. It flags any cycle skew between the copies (a timing leak) and any result mismatch. Sticky flags and counters are exposed for the formal/sim harness and for the test top.

Parameters:
DATA_W, 128, width of each SE result
CNT_W, 16, width of latency, skew and event counters (all saturate)
TIMEOUT, 1024, cycles after issue before a transaction is force-closed

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low; all state cleared while low
in_fire  in  1  SE input accepted (io_in_valid & io_in_ready); starts a transaction
validOne  in  1  SE copy one result valid
resultOne  in  DATA_W  SE copy one result
validTwo  in  1  SE copy two result valid
resultTwo  in  DATA_W  SE copy two result
clear  in  1  synchronous clear of sticky flags and counters
out_ready  out  1  ready driven to both SE copies
busy  out  1  transaction open (state != IDLE)
done  out  1  one-cycle pulse in REPORT
lat_one  out  CNT_W  latency of copy one, last transaction
lat_two  out  CNT_W  latency of copy two, last transaction
skew  out  CNT_W  |lat_one - lat_two|, last transaction
leak_detected  out  1  sticky: any transaction with skew != 0 or a missing copy
mismatch  out  1  sticky: resultOne != resultTwo on a completed transaction
timeout  out  1  sticky: a transaction hit TIMEOUT
protocol_err  out  1  sticky: in_fire while busy, or a valid while IDLE
txn_count  out  CNT_W  completed transactions
leak_count  out  CNT_W  transactions that flagged a leak

Behaviour:
- Reset value of every output is 0. State resets to IDLE.
- out_ready = 1 in WAIT_BOTH and WAIT_OTHER, 0 otherwise. A result is consumed on valid & out_ready.
- States: IDLE, WAIT_BOTH, WAIT_OTHER, REPORT.
- IDLE: on in_fire, clear the internal age counter, got_one and got_two; go to WAIT_BOTH.
- Age counter: increments each cycle in WAIT_BOTH/WAIT_OTHER and saturates at all-ones. The first cycle after in_fire samples age = 1, so the minimum latency is 1.
- WAIT_BOTH:
  - validOne → latch lat_one = age and capture resultOne; validTwo likewise.
  - Both valid in the same cycle → REPORT with skew 0.
  - Exactly one valid → WAIT_OTHER.
- WAIT_OTHER: wait for the missing copy, then latch it and go to REPORT. A repeat valid from the already-seen copy sets protocol_err and is otherwise ignored.
- Timeout: when age reaches TIMEOUT in either wait state, set timeout, latch the missing latency as all-ones, and go to REPORT.
- REPORT (1 cycle):
  - done = 1; skew = |lat_one - lat_two|.
  - txn_count += 1 (saturating).
  - If skew != 0 or a copy is missing: leak_detected = 1 and leak_count += 1.
  - If both copies arrived and the captured results differ: mismatch = 1.
  - Next state IDLE. in_fire during REPORT is a protocol_err and is not accepted.
- in_fire while busy: set protocol_err and ignore the pulse; the open transaction continues.
- validOne/validTwo while IDLE: set protocol_err; data is discarded.
- clear:
  - Zeros sticky flags, txn_count and leak_count in the next cycle, with priority over same-cycle updates.
  - lat_one, lat_two, skew and the FSM are unaffected.
- Reset low mid-transaction: immediate return to IDLE and all outputs to 0. No done pulse is produced for the aborted transaction.
- Skew subtraction is done in CNT_W unsigned, larger minus smaller.

Decomposition:
- Package selfcomp_pkg holds:
  - the state enum (IDLE/WAIT_BOTH/WAIT_OTHER/REPORT);
  - default DATA_W/CNT_W/TIMEOUT constants;
  - a sat_inc function.
- One sub-module, selfcomp_sat_counter (CNT_W, clear, inc, saturating). It is instantiated for the age counter, txn_count and leak_count.

Test Plan:
- Balanced: in_fire @t0; validOne and validTwo both @t0+3 with equal results → done @t0+4; lat_one = lat_two = 3, skew 0, txn_count 1, leak_detected 0, mismatch 0.
- Skewed: in_fire @t0; validOne @t0+2, validTwo @t0+7 → done @t0+8; lat_one 2, lat_two 7, skew 5, leak_detected 1, leak_count 1.
- Result mismatch: same timing @t0+1, resultOne = 0x1, resultTwo = 0x2 → skew 0, mismatch 1, leak_detected 0.
- Timeout: TIMEOUT = 16, only validOne @t0+4 → done @t0+17; timeout 1, leak_detected 1, lat_two all-ones.
- Protocol: in_fire again during WAIT_BOTH, and validTwo while IDLE → protocol_err 1; the original transaction completes with txn_count 1.
- Reset/clear:
  - Reset low during WAIT_OTHER → all outputs 0 and no done.
  - After two leaky transactions, clear → leak_count 0 and leak_detected 0 next cycle; lat_one/lat_two retained.
